// File: rtl/ula_pilha_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers
// for the stack-ALU sequencer.
package ula_pilha_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_SHL = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_SHR = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_LT  = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_EQ  = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_NOT = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_NEG = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP_B  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_POP_A  = 3'd3,
        ST_WAIT_A = 3'd4,
        ST_EXEC   = 3'd5,
        ST_PUSH   = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    function automatic logic is_unary(input logic [OPCODE_W-1:0] op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        return op <= OP_NEG;
    endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational stack-ALU datapath: A is the second pop, B the top of stack.
module ula_core
    import ula_pilha_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RW  = 32,
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    output logic [RW-1:0]  result
);

    logic [RW-1:0] a_z, b_z, a_s, b_s;
    logic [DW-1:0] b_inv;

    assign a_z   = {{(RW-DW){1'b0}}, a};
    assign b_z   = {{(RW-DW){1'b0}}, b};
    assign a_s   = {{(RW-DW){a[DW-1]}}, a};
    assign b_s   = {{(RW-DW){b[DW-1]}}, b};
    assign b_inv = ~b;

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD: result = a_z + b_z;
            OP_SUB: result = a_s - b_s;
            OP_MUL: result = a_z * b_z;
            OP_AND: result = a_z & b_z;
            OP_OR:  result = a_z | b_z;
            OP_XOR: result = a_z ^ b_z;
            OP_SHL: result = a_z << b[3:0];
            OP_SHR: result = a_z >> b[3:0];
            OP_LT:  result = {{(RW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  result = {{(RW-1){1'b0}}, (a == b)};
            OP_NOT: result = {{(RW-DW){1'b0}}, b_inv};
            OP_NEG: result = '0 - b_s;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ula_pilha_seq.sv
// Stack-ALU sequencer: pops operands, computes via ula_core, pushes result.
//   state   | meaning
//   IDLE    | waiting for start
//   POP_B   | pop top of stack (B), or underflow
//   WAIT_B  | capture B from stack read data
//   POP_A   | pop second operand (A), or underflow
//   WAIT_A  | capture A
//   EXEC    | register result and flags
//   PUSH    | write result through the ALU data path
//   DONE    | completion pulse, err if error path taken
module ula_pilha_seq
    import ula_pilha_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           stk_empty,
    input  logic [DW-1:0]  stk_dout,
    output logic           stk_pop,
    output logic           stk_push,
    output logic           stk_sel,
    output logic [RW-1:0]  stk_din,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           flag_z,
    output logic           flag_n
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [RW-1:0]  din_q, din_d;
    logic           z_q, z_d, n_q, n_d, err_q, err_d;
    logic [RW-1:0]  alu_res;

    ula_core #(.DW(DW), .RW(RW), .OPW(OPW)) u_core (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            din_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            din_q   <= din_d;
            z_q     <= z_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        din_d    = din_q;
        z_d      = z_q;
        n_d      = n_q;
        err_d    = err_q;
        stk_pop  = 1'b0;
        stk_push = 1'b0;
        stk_sel  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = opcode;
                    err_d = !is_legal(opcode);
                    state_d = is_legal(opcode) ? ST_POP_B : ST_DONE;
                end
            end
            ST_POP_B: begin
                if (stk_empty) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    stk_pop = 1'b1;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                b_d     = stk_dout;
                state_d = is_unary(op_q) ? ST_EXEC : ST_POP_A;
            end
            ST_POP_A: begin
                if (stk_empty) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    stk_pop = 1'b1;
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_A: begin
                a_d     = stk_dout;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                din_d   = alu_res;
                z_d     = (alu_res == '0);
                n_d     = alu_res[RW-1];
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                stk_push = 1'b1;
                stk_sel  = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign stk_din = din_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;

endmodule

// File: tb/tb_ula_pilha_seq.sv
// Randomized scoreboard bench for ula_pilha_seq with a behavioural stack and ALU model.
module tb_ula_pilha_seq;
    import ula_pilha_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  opcode;
    logic        stk_empty;
    logic [15:0] stk_dout = '0;
    logic        stk_pop, stk_push, stk_sel, busy, done, err, flag_z, flag_n;
    logic [31:0] stk_din;

    always #5 clk = ~clk;

    ula_pilha_seq #(.DW(16), .RW(32), .OPW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .stk_empty(stk_empty), .stk_dout(stk_dout),
        .stk_pop(stk_pop), .stk_push(stk_push), .stk_sel(stk_sel),
        .stk_din(stk_din), .busy(busy), .done(done), .err(err),
        .flag_z(flag_z), .flag_n(flag_n)
    );

    // Behavioural 16-entry stack with registered read data
    logic [15:0] mem [16];
    int          sp = 0;
    logic        uc_push = 1'b0, uc_clr = 1'b0;
    logic [15:0] uc_data = '0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uc_clr) sp <= 0;
        else if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
        end else if (stk_push && sp < 16) begin
            mem[sp] <= stk_din[15:0];
            sp      <= sp + 1;
        end else if (uc_push && sp < 16) begin
            mem[sp] <= uc_data;
            sp      <= sp + 1;
        end
    end
    assign stk_empty = (sp == 0);

    typedef struct {
        int          s;
        logic        err;
        int          lat;
        int          pops;
        int          push_rel;
        logic [31:0] din;
        logic        z;
        logic        n;
    } exp_t;

    exp_t        scb[$];
    logic [15:0] shadow[$];
    logic [31:0] m_din = '0;
    logic        m_z = 1'b0, m_n = 1'b0;
    int          n_pass = 0, n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        longint ua = a, ub = b, sa, sbv, r;
        sa  = (a >= 16'h8000) ? ua - 65536 : ua;
        sbv = (b >= 16'h8000) ? ub - 65536 : ub;
        case (op)
            0: r = ua + ub;
            1: r = sa - sbv;
            2: r = ua * ub;
            3: r = ua & ub;
            4: r = ua | ub;
            5: r = ua ^ ub;
            6: r = ua << (ub % 16);
            7: r = ua >> (ub % 16);
            8: r = (sa < sbv) ? 1 : 0;
            9: r = (ua == ub) ? 1 : 0;
            10: r = 65535 - ub;
            11: r = -sbv;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // Monitor: pops the expected response whenever the DUT signals done
    int   mon_pops = 0, mon_first_pop = -1, mon_pushes = 0, mon_push_rel = -1;
    exp_t me;
    always @(negedge clk) begin
        if (!rst) begin
            scb.delete();
            mon_pops = 0; mon_pushes = 0; mon_first_pop = -1; mon_push_rel = -1;
        end
        if (stk_pop || stk_push) chk("pop_push_exclusive", stk_pop & stk_push, 0);
        if (stk_push || stk_sel) chk("sel_matches_push", stk_sel, stk_push);
        if (scb.size() > 0) begin
            if (stk_pop) begin
                if (mon_pops == 0) mon_first_pop = cyc - scb[0].s;
                mon_pops++;
            end
            if (stk_push) begin
                mon_push_rel = cyc - scb[0].s;
                mon_pushes++;
            end
        end else if (stk_pop || stk_push) chk("stray_stack_traffic", 1, 0);
        if (done) begin
            if (scb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                me = scb.pop_front();
                chk("done_latency", cyc - me.s, me.lat);
                chk("err", err, me.err);
                chk("busy_at_done", busy, 1);
                chk("pop_count", mon_pops, me.pops);
                if (me.pops > 0) chk("first_pop_cycle", mon_first_pop, 1);
                chk("push_count", mon_pushes, me.err ? 0 : 1);
                if (!me.err) chk("push_cycle", mon_push_rel, me.push_rel);
                chk("stk_din", stk_din, me.din);
                chk("flag_z", flag_z, me.z);
                chk("flag_n", flag_n, me.n);
            end
            mon_pops = 0; mon_pushes = 0; mon_first_pop = -1; mon_push_rel = -1;
        end else if (err) chk("err_without_done", 1, 0);
    end

    task automatic push_word(input logic [15:0] v);
        @(negedge clk); uc_push = 1'b1; uc_data = v; shadow.push_back(v);
        @(negedge clk); uc_push = 1'b0;
    endtask

    task automatic clear_stack();
        @(negedge clk); uc_clr = 1'b1;
        @(negedge clk); uc_clr = 1'b0;
        shadow.delete();
    endtask

    task automatic issue(input int op);
        exp_t        e;
        logic [15:0] a, b;
        int          need;
        e.err = 1'b0; e.pops = 0; e.push_rel = 0; a = '0;
        if (op > 11) begin
            e.err = 1'b1; e.lat = 1;
        end else begin
            need = (op == 10 || op == 11) ? 1 : 2;
            if (shadow.size() == 0) begin
                e.err = 1'b1; e.lat = 2;
            end else begin
                b = shadow.pop_back(); e.pops = 1;
                if (need == 2 && shadow.size() == 0) begin
                    e.err = 1'b1; e.lat = 4;
                end else begin
                    if (need == 2) begin a = shadow.pop_back(); e.pops = 2; end
                    m_din = ref_alu(op, a, b);
                    m_z   = (m_din == 0);
                    m_n   = m_din[31];
                    shadow.push_back(m_din[15:0]);
                    e.lat      = (need == 2) ? 7 : 5;
                    e.push_rel = (need == 2) ? 6 : 4;
                end
            end
        end
        e.din = m_din; e.z = m_z; e.n = m_n;
        @(negedge clk);
        start = 1'b1; opcode = 4'(op); e.s = cyc;
        scb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && scb.size() != 0; i++) @(negedge clk);
        if (scb.size() != 0) chk("drain_timeout", scb.size(), 0);
        @(negedge clk);
        chk("stack_depth", sp, shadow.size());
    endtask

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'(($urandom_range(0, 20)));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; opcode = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outputs", {stk_pop, stk_push, stk_sel, busy, done, err, flag_z, flag_n}, 0);
        chk("reset_stk_din", stk_din, 0);
        rst = 1'b1;

        clear_stack(); push_word(16'd7); push_word(16'd5); issue(OP_ADD); drain();
        chk("add_7_5", stk_din, 32'h0000_000C);
        clear_stack(); push_word(16'd3); push_word(16'd5); issue(OP_SUB); drain();
        chk("sub_3_5", stk_din, 32'hFFFF_FFFE);
        chk("sub_flag_n", flag_n, 1);
        clear_stack(); push_word(16'hFFFF); push_word(16'hFFFF); issue(OP_MUL); drain();
        chk("mul_ffff", stk_din, 32'hFFFE_0001);
        clear_stack(); push_word(16'h00F0); issue(OP_NOT); drain();
        chk("not_00f0", stk_din, 32'h0000_FF0F);

        clear_stack(); push_word(16'd1); issue(OP_ADD); drain();
        chk("underflow_leaves_empty", sp, 0);
        issue(13); drain();

        // start pulsed while busy must be ignored
        clear_stack(); push_word(16'd7); push_word(16'd5); issue(OP_ADD);
        start = 1'b1; opcode = OP_SUB;
        @(negedge clk); start = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        chk("ignored_start_depth", sp, 1);

        // async reset while waiting on the second operand
        clear_stack(); push_word(16'd9); push_word(16'd4); issue(OP_ADD);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_ctrl", {stk_pop, stk_push, stk_sel, busy, done, err, flag_z, flag_n}, 0);
        chk("async_reset_din", stk_din, 0);
        m_din = '0; m_z = 1'b0; m_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_stack(); push_word(16'd2); push_word(16'd2); issue(OP_ADD); drain();
        chk("add_after_reset", stk_din, 32'd4);

        for (int it = 0; it < 60; it++) begin
            int op, need, depth;
            op   = $urandom_range(0, 15);
            need = (op > 11) ? 0 : ((op == 10 || op == 11) ? 1 : 2);
            depth = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : need;
            clear_stack();
            for (int k = 0; k < depth; k++) push_word(rnd_word());
            issue(op);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
